// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_INC = 1;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry valid/ready holding register between fetch and decode.
module fetch_out_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             flush,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] pc,
  output logic             valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc
);

  // flush beats load beats pop; payload is frozen unless a new entry lands
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end else if (pop) begin
        valid <= 1'b0;
      end
      if (load && !flush) begin
        inst    <= data;
        inst_pc <= pc;
      end
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and single-outstanding req/gnt/rvalid fetch sequencer feeding decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_base_i,
  input  logic [WIDTH-1:0] redirect_off_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic             imem_gnt_i,
  input  logic             imem_rvalid_i,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic             inst_valid_o,
  output logic [WIDTH-1:0] inst_o,
  output logic [WIDTH-1:0] inst_pc_o,
  input  logic             inst_ready_i
);

  fetch_state_t     state, state_d;
  logic [WIDTH-1:0] pc, pc_d;
  logic [WIDTH-1:0] fetch_pc, fetch_pc_d;
  logic             squash, squash_d;
  logic             buf_free;
  logic             grant;
  logic             load;

  assign buf_free    = !inst_valid_o || inst_ready_i;
  assign imem_addr_o = pc;
  assign imem_req_o  = (state == FETCH) && buf_free && !rst;
  assign grant       = imem_req_o && imem_gnt_i;
  assign load        = (state == WAIT) && imem_rvalid_i && !squash && !redirect_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      fetch_pc <= '0;
      squash   <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      fetch_pc <= fetch_pc_d;
      squash   <= squash_d;
    end
  end

  // A redirect retargets pc and marks any in-flight response as stale
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    fetch_pc_d = fetch_pc;
    squash_d   = squash;
    case (state)
      FETCH: begin
        if (grant) begin
          fetch_pc_d = pc;
          pc_d       = pc + WIDTH'(PC_INC);
          state_d    = WAIT;
          if (redirect_i) squash_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          state_d  = FETCH;
          squash_d = 1'b0;
        end else if (redirect_i) begin
          squash_d = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
    if (redirect_i) pc_d = redirect_base_i + redirect_off_i;
  end

  fetch_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .flush   (redirect_i),
    .pop     (inst_ready_i),
    .data    (imem_rdata_i),
    .pc      (fetch_pc),
    .valid   (inst_valid_o),
    .inst    (inst_o),
    .inst_pc (inst_pc_o)
  );

endmodule
